// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/hold/flush sequencer.
// Merges memory wait, multi-cycle execute, load-use and taken-branch causes
// into per-stage enables and flushes, and keeps saturating stall/flush counters.
module pipeline_stall_controller #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_use_hazard,
    input  logic                 branch_taken,
    input  logic                 ex_multicycle_start,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 ex_hold,
    output logic                 mem_hold,
    output logic [1:0]           busy_state,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    // Multi-cycle ops hold EX for MUL_LATENCY-1 cycles; the start cycle is the
    // first of them, so the remaining counter is loaded with MUL_LATENCY-2.
    localparam bit          MC_EN     = (MUL_LATENCY >= 2);
    localparam int unsigned START_REM = MC_EN ? (MUL_LATENCY - 2) : 0;
    localparam int unsigned REM_W     = (START_REM > 1) ? $clog2(START_REM + 1) : 1;
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(START_REM);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EX_BUSY  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    state_t           resume, resume_nxt;
    state_t           eff_state;
    logic [REM_W-1:0] rem, rem_nxt;
    logic             mem_wait;
    logic             ex_start;
    logic             ex_active;

    // State, remaining-hold counter and pre-wait state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            resume <= RUN;
            rem    <= '0;
        end else begin
            state  <= state_nxt;
            resume <= resume_nxt;
            rem    <= rem_nxt;
        end
    end

    // Cause decode and next-state selection.
    // While in MEM_WAIT, the lower causes see the state that was interrupted,
    // so a release cycle continues an EX hold exactly where it was frozen.
    always_comb begin
        eff_state  = (state == MEM_WAIT) ? resume : state;
        mem_wait   = dmem_req && !dmem_ready;
        ex_start   = MC_EN && (eff_state == RUN) && ex_multicycle_start;
        ex_active  = (eff_state == EX_BUSY) || ex_start;
        state_nxt  = RUN;
        resume_nxt = resume;
        rem_nxt    = rem;
        if (mem_wait) begin
            state_nxt  = MEM_WAIT;
            resume_nxt = eff_state;
        end else if (eff_state == EX_BUSY) begin
            if (rem != '0) begin
                rem_nxt = rem - REM_ONE;
            end
            state_nxt = (rem <= REM_ONE) ? RUN : EX_BUSY;
        end else if (ex_start) begin
            rem_nxt   = REM_LOAD;
            state_nxt = (REM_LOAD != '0) ? EX_BUSY : RUN;
        end
    end

    // Prioritised control outputs; reset forces the idle set
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        mem_hold     = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                mem_hold    = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (ex_active) begin
                ex_hold     = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (load_use_hazard) begin
                id_ex_bubble = 1'b1;
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
            end else if (branch_taken) begin
                if_id_flush = 1'b1;
            end
        end
    end

    assign busy_state = state;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
            if (if_id_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: three instances (MUL_LATENCY=4,
// MUL_LATENCY=1, CNT_WIDTH=4) share one directed stimulus stream and are
// compared every cycle against a hold-count model, plus literal checks.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, load_use_hazard, branch_taken, ex_multicycle_start, dmem_req, dmem_ready;

    logic [2:0]  pc_w, ifid_w, flush_o, bubble_o, exh_o, memh_o;
    logic [1:0]  busy_a, busy_b, busy_c;
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
    logic [3:0]  stall_c, flush_c;

    pipeline_stall_controller #(.MUL_LATENCY(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .ex_multicycle_start(ex_multicycle_start), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_w[0]), .if_id_write(ifid_w[0]), .if_id_flush(flush_o[0]),
        .id_ex_bubble(bubble_o[0]), .ex_hold(exh_o[0]), .mem_hold(memh_o[0]),
        .busy_state(busy_a), .stall_cycles(stall_a), .flush_count(flush_a));

    pipeline_stall_controller #(.MUL_LATENCY(1), .CNT_WIDTH(32)) dut_l1 (
        .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .ex_multicycle_start(ex_multicycle_start), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_w[1]), .if_id_write(ifid_w[1]), .if_id_flush(flush_o[1]),
        .id_ex_bubble(bubble_o[1]), .ex_hold(exh_o[1]), .mem_hold(memh_o[1]),
        .busy_state(busy_b), .stall_cycles(stall_b), .flush_count(flush_b));

    pipeline_stall_controller #(.MUL_LATENCY(4), .CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .ex_multicycle_start(ex_multicycle_start), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_w[2]), .if_id_write(ifid_w[2]), .if_id_flush(flush_o[2]),
        .id_ex_bubble(bubble_o[2]), .ex_hold(exh_o[2]), .mem_hold(memh_o[2]),
        .busy_state(busy_c), .stall_cycles(stall_c), .flush_count(flush_c));

    int errors = 0;
    int checks = 0;

    // Model: per instance, the number of EX hold cycles still owed, whether a
    // memory wait is in progress, and the two event counts with their ceilings.
    int unsigned       lat[3]  = '{4, 1, 4};
    longint unsigned   cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    int                hl[3];
    bit                wt[3];
    longint unsigned   m_st[3], m_fl[3];

    // Per-test tallies of the main instance's observed outputs
    int hold_n, memh_n, busy2_n, busy1_n, l1_hold;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_tally();
        hold_n = 0; memh_n = 0; busy2_n = 0; busy1_n = 0; l1_hold = 0;
    endtask

    // One clock cycle: drive inputs, check the Mealy outputs mid-cycle,
    // advance the model, then check registered outputs after the edge.
    // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mem_hold}
    task automatic step(input bit r, input bit lu, input bit br, input bit st,
                        input bit rq, input bit rd);
        logic [5:0]      e, a;
        bit              memw, exa;
        longint unsigned bs, sc, fc;
        rst = r; load_use_hazard = lu; branch_taken = br;
        ex_multicycle_start = st; dmem_req = rq; dmem_ready = rd;
        #3;
        for (int i = 0; i < 3; i++) begin
            memw = rq && !rd;
            exa  = (hl[i] > 0) || (st && lat[i] >= 2);
            if (r)         e = 6'b110000;
            else if (memw) e = 6'b000001;
            else if (exa)  e = 6'b000010;
            else if (lu)   e = 6'b000100;
            else if (br)   e = 6'b111000;
            else           e = 6'b110000;
            a = {pc_w[i], ifid_w[i], flush_o[i], bubble_o[i], exh_o[i], memh_o[i]};
            chk($sformatf("ctrl[%0d]", i), a, e);
            if (r) begin
                hl[i] = 0; wt[i] = 1'b0; m_st[i] = 0; m_fl[i] = 0;
            end else begin
                if (!e[5] && m_st[i] < cmax[i]) m_st[i]++;
                if (e[3] && m_fl[i] < cmax[i]) m_fl[i]++;
                if (memw) begin
                    wt[i] = 1'b1;
                end else begin
                    wt[i] = 1'b0;
                    if (hl[i] > 0) hl[i]--;
                    else if (st && lat[i] >= 2) hl[i] = lat[i] - 2;
                end
            end
        end
        if (exh_o[0]) hold_n++;
        if (memh_o[0]) memh_n++;
        if (busy_a == 2'd2) busy2_n++;
        if (busy_a == 2'd1) busy1_n++;
        if (exh_o[1]) l1_hold++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin bs = busy_a; sc = stall_a; fc = flush_a; end
                1:       begin bs = busy_b; sc = stall_b; fc = flush_b; end
                default: begin bs = busy_c; sc = stall_c; fc = flush_c; end
            endcase
            chk($sformatf("busy[%0d]", i), bs, wt[i] ? 1 : (hl[i] > 0 ? 2 : 0));
            chk($sformatf("stall[%0d]", i), sc, m_st[i]);
            chk($sformatf("flush[%0d]", i), fc, m_fl[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; load_use_hazard = 1'b0; branch_taken = 1'b0;
        ex_multicycle_start = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hl[i] = 0; wt[i] = 1'b0; m_st[i] = 0; m_fl[i] = 0;
        end
        clear_tally();
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_stall", stall_a, 0);

        // Load-use beats a simultaneous branch
        step(0, 1, 1, 0, 0, 0);
        chk("lu_stall", stall_a, 1);
        chk("lu_flush", flush_a, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0);

        // Back-to-back taken branches
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("br_flush", flush_a, 2);
        chk("br_stall", stall_a, 0);
        step(1, 0, 0, 0, 0, 0);

        // Multi-cycle op: 3 holds at latency 4, none at latency 1
        clear_tally();
        step(0, 0, 0, 1, 0, 0);
        idle(4);
        chk("mc_holds", hold_n, 3);
        chk("mc_busy2", busy2_n, 2);
        chk("mc_l1_holds", l1_hold, 0);
        chk("mc_l1_stall", stall_b, 0);
        step(1, 0, 0, 0, 0, 0);

        // Memory wait on the second hold cycle of a multi-cycle op
        clear_tally();
        step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        idle(3);
        chk("mw_holds", hold_n, 3);
        chk("mw_memh", memh_n, 5);
        chk("mw_busy1", busy1_n, 5);
        chk("mw_stall", stall_a, 8);
        step(1, 0, 0, 0, 0, 0);

        // Reset in the middle of EX_BUSY, then a fresh op
        step(0, 0, 0, 1, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_stall", stall_a, 0);
        clear_tally();
        step(0, 0, 0, 1, 0, 0);
        idle(4);
        chk("rst_fresh_holds", hold_n, 3);

        // Counter saturation in the 4-bit instance
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1, 0);
        chk("sat_c4", stall_c, 15);
        chk("sat_main", stall_a, 20);
        step(0, 0, 1, 0, 0, 0);
        chk("sat_flush_c4", flush_c, 1);
        step(1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage pipeline's stall, hold and flush controls. Sits beside the decode stage.
- Merges four stall/flush causes into one per-stage enable/flush set:
  - load-use hazard and taken branch, both from decode;
  - multi-cycle execute ops (MUL/DIV);
  - wait-stated data memory.
- Keeps saturating stall and flush performance counters.

Parameters:
- MUL_LATENCY, 4: total EX cycles of a multi-cycle op. EX is held for MUL_LATENCY-1 cycles. Values 0 and 1 mean no hold.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- load_use_hazard  input  1  ID/EX load whose rd matches a source register of the ID instruction
- branch_taken  input  1  PCSrc from decode, branch resolved taken in ID
- ex_multicycle_start  input  1  multi-cycle op in EX; high only on its first EX cycle
- dmem_req  input  1  MEM stage performs a data memory access this cycle
- dmem_ready  input  1  data memory completes the access this cycle
- pc_write  output  1  PC register enable
- if_id_write  output  1  IF/ID register enable
- if_id_flush  output  1  zero the IF/ID instruction on next edge
- id_ex_bubble  output  1  load zero control into ID/EX
- ex_hold  output  1  hold ID/EX, insert bubble into EX/MEM
- mem_hold  output  1  freeze all pipeline registers, including MEM/WB
- busy_state  output  2  0=RUN, 1=MEM_WAIT, 2=EX_BUSY
- stall_cycles  output  CNT_WIDTH  count of cycles with pc_write=0
- flush_count  output  CNT_WIDTH  count of cycles with if_id_flush=1

Behaviour:
- Outputs are combinational (Mealy) from state, counter and inputs. State and counters are registered.
- While rst=1:
  - pc_write=1, if_id_write=1, all other control outputs 0.
  - Next state RUN, remaining counter 0, both performance counters 0, busy_state=0 after the edge.
- Idle output set: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, ex_hold=0, mem_hold=0.
- Causes are evaluated every cycle in the order 1-5 below. Only the highest active cause acts; lower causes are ignored that cycle.

1. Memory wait: dmem_req=1 and dmem_ready=0.
   - mem_hold=1, pc_write=0, if_id_write=0, all others 0.
   - Next state MEM_WAIT. The remaining counter is frozen.
2. Execute busy: state EX_BUSY, or RUN with ex_multicycle_start=1 and MUL_LATENCY>=2.
   - ex_hold=1, pc_write=0, if_id_write=0.
   - On start, load rem=MUL_LATENCY-2 and go to EX_BUSY if rem>0, else stay RUN.
   - In EX_BUSY, decrement rem; leave for RUN on the edge where rem==1 is decremented.
   - Result: exactly MUL_LATENCY-1 consecutive ex_hold cycles, excluding cycles lost to memory waits.
3. Load-use: load_use_hazard=1.
   - pc_write=0, if_id_write=0, id_ex_bubble=1.
   - branch_taken is ignored; decode re-resolves the branch next cycle.
4. Branch: branch_taken=1.
   - if_id_flush=1, pc_write=1, if_id_write=1.
5. None active: idle output set.

- MEM_WAIT exit:
  - The cycle with dmem_ready=1 is a release cycle. Cause 1 is inactive, so the lower causes are evaluated normally.
  - Next state is EX_BUSY if rem>0 was frozen there, otherwise RUN.
  - MEM_WAIT records the pre-wait state in one extra register.
- ex_multicycle_start arriving while already in EX_BUSY is ignored; the first op owns EX.
- Counters:
  - stall_cycles +1 on each cycle with pc_write=0.
  - flush_count +1 on each cycle with if_id_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: EX_BUSY or MEM_WAIT is abandoned immediately and rem is cleared.
- No two of mem_hold, ex_hold, id_ex_bubble, if_id_flush are ever 1 in the same cycle.

Test Plan:
1. Load-use: rst low, load_use_hazard=1 for 1 cycle with branch_taken=1 -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0; stall_cycles=1 afterwards; next cycle idle.
2. Branch: branch_taken=1 for 2 consecutive cycles -> if_id_flush=1 both cycles, pc_write=1; flush_count=2, stall_cycles=0.
3. Multi-cycle with MUL_LATENCY=4: ex_multicycle_start pulse -> ex_hold=1 for exactly 3 cycles, busy_state=2 for 2 cycles, then idle. Repeat with MUL_LATENCY=1 -> no hold.
4. Memory wait inside multi-cycle (MUL_LATENCY=4): start, then dmem_req=1 with dmem_ready=0 for 5 cycles on the 2nd hold cycle -> mem_hold=1 for 5 cycles, ex_hold=0 there, busy_state=1; afterwards ex_hold resumes for its remaining 2 cycles, 3 in total; stall_cycles=8.
5. Reset mid-EX_BUSY: assert rst for 1 cycle -> outputs idle set, busy_state=0, counters 0; following ex_multicycle_start behaves as a fresh op.
6. Saturation with CNT_WIDTH=4: hold mem wait for 20 cycles -> stall_cycles stops at 15.
